// File: rtl/chirp_pinc_gen.sv
// Chirp generator: steps a DDS phase-increment word linearly over AXI-stream. Optional up/down sweep under `CHIRP_TRIANGLE_EN`.
// Latency: first beat is valid one cycle after gen in IDLE; chirps run back to back with no bubble.
// Backpressure: all counters advance only on accepted beats; tdata/tlast hold while tready is low.
module chirp_pinc_gen #(
    parameter int PINC_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              gen,
    input  logic              abort,
    input  logic [PINC_W-1:0] pinc_start,
    input  logic [PINC_W-1:0] pinc_step,
    input  logic [CNT_W-1:0]  num_steps,
    input  logic [CNT_W-1:0]  dwell,
    input  logic [CNT_W-1:0]  num_chirps,
    input  logic              triangle,
    output logic [PINC_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              busy,
    output logic              done
);

`ifdef CHIRP_TRIANGLE_EN
    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;
`else
    typedef enum logic [1:0] {IDLE, UP} state_t;
`endif

    state_t            state;
    logic [PINC_W-1:0] start_q;
    logic [PINC_W-1:0] step_q;
    logic [PINC_W-1:0] pinc_q;
    logic [CNT_W-1:0]  nsteps_q;
    logic [CNT_W-1:0]  dwell_m1_q;
    logic [CNT_W-1:0]  nchirps_q;
    logic [CNT_W-1:0]  dwell_cnt;
    logic [CNT_W-1:0]  step_idx;
    logic [CNT_W-1:0]  chirp_cnt;
    logic [CNT_W-1:0]  chirp_nxt;
    logic              done_q;
    logic              step_end;
    logic              peak;
    logic              chirp_end;
    logic              last_chirp;

`ifdef CHIRP_TRIANGLE_EN
    logic tri_q;
    logic to_down;

    // A zero-length ramp has no down leg, so the chirp ends at the single peak step.
    assign to_down   = tri_q && (nsteps_q != '0);
    assign chirp_end = step_end && (((state == UP) && peak && !to_down) ||
                                    ((state == DOWN) && (step_idx == '0)));
`else
    logic unused_triangle;

    assign unused_triangle = triangle;
    assign chirp_end       = step_end && (state == UP) && peak;
`endif

    assign step_end   = (dwell_cnt == dwell_m1_q);
    assign peak       = (step_idx == nsteps_q);
    assign chirp_nxt  = chirp_cnt + CNT_W'(1);
    // Continuous mode (num_chirps == 0) never terminates, even when chirp_cnt wraps.
    assign last_chirp = (nchirps_q != '0) && (chirp_nxt == nchirps_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            start_q    <= '0;
            step_q     <= '0;
            pinc_q     <= '0;
            nsteps_q   <= '0;
            dwell_m1_q <= '0;
            nchirps_q  <= '0;
            dwell_cnt  <= '0;
            step_idx   <= '0;
            chirp_cnt  <= '0;
            done_q     <= 1'b0;
`ifdef CHIRP_TRIANGLE_EN
            tri_q      <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                state  <= IDLE;
                pinc_q <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (gen) begin
                            start_q    <= pinc_start;
                            step_q     <= pinc_step;
                            nsteps_q   <= num_steps;
                            dwell_m1_q <= (dwell == '0) ? '0 : dwell - CNT_W'(1);
                            nchirps_q  <= num_chirps;
`ifdef CHIRP_TRIANGLE_EN
                            tri_q      <= triangle;
`endif
                            pinc_q     <= pinc_start;
                            dwell_cnt  <= '0;
                            step_idx   <= '0;
                            chirp_cnt  <= '0;
                            state      <= UP;
                        end
                    end
                    default: begin
                        if (m_axis_tready) begin
                            if (!step_end) begin
                                dwell_cnt <= dwell_cnt + CNT_W'(1);
                            end else begin
                                dwell_cnt <= '0;
                                if (chirp_end) begin
                                    chirp_cnt <= chirp_nxt;
                                    step_idx  <= '0;
                                    if (last_chirp) begin
                                        state  <= IDLE;
                                        pinc_q <= '0;
                                        done_q <= 1'b1;
                                    end else begin
                                        state  <= UP;
                                        pinc_q <= start_q;
                                    end
`ifdef CHIRP_TRIANGLE_EN
                                end else if ((state == UP) && !peak) begin
                                    step_idx <= step_idx + CNT_W'(1);
                                    pinc_q   <= pinc_q + step_q;
                                end else if (state == UP) begin
                                    // Turn around below the peak so the peak value is not repeated.
                                    state    <= DOWN;
                                    step_idx <= nsteps_q - CNT_W'(1);
                                    pinc_q   <= pinc_q - step_q;
                                end else begin
                                    step_idx <= step_idx - CNT_W'(1);
                                    pinc_q   <= pinc_q - step_q;
                                end
`else
                                end else begin
                                    step_idx <= step_idx + CNT_W'(1);
                                    pinc_q   <= pinc_q + step_q;
                                end
`endif
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign m_axis_tdata  = pinc_q;
    assign m_axis_tvalid = (state != IDLE);
    assign m_axis_tlast  = m_axis_tvalid && chirp_end;
    assign busy          = (state != IDLE);
    assign done          = done_q;

endmodule

// File: tb/tb_chirp_pinc_gen.sv
// Bench for chirp_pinc_gen: random-ready sweeps scored against a closed-form chirp model.
module tb_chirp_pinc_gen;
    localparam int PW = 16;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst, gen, abort, triangle, tready;
    logic [PW-1:0] pinc_start, pinc_step, tdata;
    logic [CW-1:0] num_steps, dwell, num_chirps;
    logic          tvalid, tlast, busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    chirp_pinc_gen #(.PINC_W(PW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .gen(gen), .abort(abort),
        .pinc_start(pinc_start), .pinc_step(pinc_step), .num_steps(num_steps),
        .dwell(dwell), .num_chirps(num_chirps), .triangle(triangle),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .m_axis_tlast(tlast), .busy(busy), .done(done)
    );

    // Triangle input only has an effect in builds with the down leg.
    function automatic bit tri_eff(bit t);
`ifdef CHIRP_TRIANGLE_EN
        return t;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int chirp_len(int ns, int d, bit t);
        return ((ns + 1) + ((t && ns > 0) ? ns : 0)) * ((d == 0) ? 1 : d);
    endfunction

    // Beat b of an endless run: position within chirp -> step position -> ramp index.
    function automatic logic [PW-1:0] exp_data(int start, int step, int ns, int d, bit t, int b);
        int dd, p, k, j, v;
        dd = (d == 0) ? 1 : d;
        p  = b % chirp_len(ns, d, t);
        k  = p / dd;
        j  = (k <= ns) ? k : 2 * ns - k;
        v  = start + j * step;
        return v[PW-1:0];
    endfunction

    function automatic bit exp_last(int ns, int d, bit t, int b);
        int len;
        len = chirp_len(ns, d, t);
        return (b % len) == (len - 1);
    endfunction

    task automatic run_sweep(input string name, input int start, input int step, input int ns,
                             input int d, input int chirps, input bit t, input int mode,
                             input int n_beats, input bit do_abort);
        int            idx, cyc, limit;
        bit            dead, prev_v, prev_r, prev_l, te;
        logic [PW-1:0] prev_d, ed;
        logic          el;
        te = tri_eff(t);
        idx = 0; cyc = 0; dead = 0; prev_v = 0; prev_r = 0; prev_l = 0; prev_d = '0;
        limit = n_beats * 6 + 20;
        @(negedge clk);
        pinc_start = PW'(start); pinc_step = PW'(step); num_steps = CW'(ns);
        dwell = CW'(d); num_chirps = CW'(chirps); triangle = t;
        gen = 1'b1; abort = 1'b0; tready = 1'b0;
        while (idx < n_beats && cyc < limit && !dead) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                n_tests++;
                if (tvalid !== 1'b1 || tdata !== PW'(start)) begin
                    n_fail++;
                    $display("FAIL %s first_beat: tvalid=%b tdata=%h, need tvalid=1 tdata=%h",
                             name, tvalid, tdata, PW'(start));
                end
            end
            if (prev_v && !prev_r) begin
                n_tests++;
                if (tvalid !== 1'b1 || tdata !== prev_d || tlast !== prev_l) begin
                    n_fail++;
                    $display("FAIL %s stall_hold cyc %0d: v=%b d=%h l=%b, need v=1 d=%h l=%b",
                             name, cyc, tvalid, tdata, tlast, prev_d, prev_l);
                end
            end
            case (mode)
                0:       tready = 1'b1;
                1:       tready = (cyc % 2) == 1;
                default: tready = ($urandom_range(0, 3) != 0);
            endcase
            if (tvalid !== 1'b1) begin
                n_tests++;
                n_fail++;
                dead = 1;
                $display("FAIL %s bubble at beat %0d: tvalid=%b, need 1", name, idx, tvalid);
            end else if (tready) begin
                ed = exp_data(start, step, ns, d, te, idx);
                el = exp_last(ns, d, te, idx);
                n_tests++;
                if (tdata !== ed || tlast !== el) begin
                    n_fail++;
                    $display("FAIL %s beat %0d: tdata=%h tlast=%b, need tdata=%h tlast=%b",
                             name, idx, tdata, tlast, ed, el);
                end
                idx++;
            end
            prev_v = tvalid; prev_r = tready; prev_d = tdata; prev_l = tlast;
            gen = 1'(($urandom_range(0, 1)));
            pinc_start = PW'($urandom); pinc_step = PW'($urandom);
            num_steps = $urandom; dwell = $urandom; num_chirps = $urandom; triangle = 1'($urandom);
        end
        gen = 1'b0;
        if (idx < n_beats) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s beat_count: accepted %0d, need %0d", name, idx, n_beats);
        end
        if (do_abort) begin
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            n_tests++;
            if (tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || tlast !== 1'b0) begin
                n_fail++;
                $display("FAIL %s abort: v=%b busy=%b done=%b last=%b, need all 0",
                         name, tvalid, busy, done, tlast);
            end
            @(negedge clk);
            n_tests++;
            if (done !== 1'b0 || tvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL %s abort_no_done: done=%b v=%b, need 0 0", name, done, tvalid);
            end
        end else begin
            @(negedge clk);
            n_tests++;
            if (tvalid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL %s done_pulse: v=%b done=%b busy=%b, need 0 1 0",
                         name, tvalid, done, busy);
            end
            @(negedge clk);
            n_tests++;
            if (done !== 1'b0 || tvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL %s done_width: done=%b v=%b, need 0 0", name, done, tvalid);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; gen = 1'b1; abort = 1'b0; tready = 1'b1; triangle = 1'b0;
        pinc_start = 16'h1234; pinc_step = 16'h1; num_steps = 3; dwell = 1; num_chirps = 1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({tdata, tvalid, tlast, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: d=%h v=%b l=%b busy=%b done=%b, need all 0",
                     tdata, tvalid, tlast, busy, done);
        end
        gen = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: v=%b busy=%b done=%b, need 0 0 0", tvalid, busy, done);
        end
    endtask

    task automatic test_saw_long();
        run_sweep("saw_long", 5086, 1, 314, 26, 1, 1'b0, 0, 315 * 26, 1'b0);
    endtask

    task automatic test_triangle();
        run_sweep("triangle", 100, 10, 3, 1, 2, 1'b1, 0, 2 * chirp_len(3, 1, tri_eff(1'b1)), 1'b0);
    endtask

    task automatic test_tri_ignored_single();
        run_sweep("tri_one_chirp", 100, 10, 3, 1, 1, 1'b1, 2, chirp_len(3, 1, tri_eff(1'b1)), 1'b0);
    endtask

    task automatic test_stall();
        run_sweep("stall_toggle", 5086, 1, 314, 26, 1, 1'b0, 1, 315 * 26, 1'b0);
    endtask

    task automatic test_wrap();
        run_sweep("wrap", 16'hFFF0, 16'h0010, 2, 0, 1, 1'b0, 0, 3, 1'b0);
    endtask

    task automatic test_tri_single_step();
        run_sweep("tri_ns0", 16'h0ABC, 16'h0100, 0, 3, 2, 1'b1, 2, 2 * 3, 1'b0);
    endtask

    task automatic test_continuous_abort();
        run_sweep("cont_abort", 200, 7, 4, 1, 0, 1'b1, 2, 500, 1'b1);
    endtask

    task automatic test_abort_gen_idle();
        @(negedge clk);
        gen = 1'b1; abort = 1'b1;
        @(negedge clk);
        gen = 1'b0; abort = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_gen_idle: busy=%b v=%b, need 0 0", busy, tvalid);
        end
    endtask

    task automatic test_rst_mid();
        @(negedge clk);
        pinc_start = 16'h0400; pinc_step = 16'h0003; num_steps = 20; dwell = 2;
        num_chirps = 0; triangle = 1'b0; gen = 1'b1; tready = 1'b1;
        @(negedge clk);
        gen = 1'b0;
        repeat (50) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({tdata, tvalid, tlast, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_async: d=%h v=%b l=%b busy=%b done=%b, need all 0",
                     tdata, tvalid, tlast, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_no_restart: v=%b busy=%b done=%b, need 0 0 0", tvalid, busy, done);
        end
    endtask

    task automatic test_random();
        int st, sp, ns, d, ch;
        bit t;
        for (int i = 0; i < 6; i++) begin
            st = int'($urandom_range(0, 16'hFFFF));
            sp = int'($urandom_range(0, 16'hFFFF));
            ns = int'($urandom_range(0, 6));
            d  = int'($urandom_range(0, 3));
            ch = int'($urandom_range(1, 3));
            t  = 1'($urandom);
            run_sweep("random", st, sp, ns, d, ch, t, 2, ch * chirp_len(ns, d, tri_eff(t)), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_saw_long();
        test_triangle();
        test_tri_ignored_single();
        test_stall();
        test_wrap();
        test_tri_single_step();
        test_continuous_abort();
        test_abort_gen_idle();
        test_rst_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/chirp_pinc_gen.md
CHIRP_PINC_GEN -- requirements
Module: chirp_pinc_gen

Interface
REQ-001 SHALL have parameter PINC_W, default 16, phase-increment word width.
REQ-002 SHALL have parameter CNT_W, default 32, width of step, dwell and chirp counters.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 gen  in  1  start request, sampled only in IDLE.
REQ-006 abort  in  1  stop the sweep immediately; wins over every other input except rst.
REQ-007 pinc_start  in  PINC_W  first phase increment of each chirp.
REQ-008 pinc_step  in  PINC_W  increment added per step, unsigned.
REQ-009 num_steps  in  CNT_W  highest step index; up-ramp covers indices 0..num_steps.
REQ-010 dwell  in  CNT_W  accepted beats per step value; 0 is treated as 1.
REQ-011 num_chirps  in  CNT_W  chirps per run; 0 means continuous until abort.
REQ-012 triangle  in  1  1 = up/down sweep, 0 = sawtooth.
REQ-013 m_axis_tdata  out  PINC_W  current phase increment for the DDS.
REQ-014 m_axis_tvalid  out  1  tdata valid.
REQ-015 m_axis_tready  in  1  downstream accept.
REQ-016 m_axis_tlast  out  1  high on the final beat of each chirp.
REQ-017 busy  out  1  high in any state other than IDLE.
REQ-018 done  out  1  one-cycle pulse when a finite run completes.

Function
REQ-019 States SHALL be IDLE, UP and DOWN; DOWN exists only when CHIRP_TRIANGLE_EN is defined.
REQ-020 In IDLE, gen=1 SHALL latch all configuration inputs and enter UP with step index j=0; tvalid=1 and tdata=pinc_start on the next cycle.
REQ-021 Configuration inputs SHALL be ignored outside the gen cycle, and gen SHALL be ignored while busy.
REQ-022 tdata SHALL equal (pinc_start + j*pinc_step) mod 2^PINC_W, computed by accumulation with no saturation.
REQ-023 The dwell counter, step index and chirp counter SHALL advance only on a beat where tvalid=1 and tready=1; tdata/tvalid/tlast SHALL hold stable while tready=0.
REQ-024 Each step value SHALL be presented for exactly max(dwell,1) accepted beats.
REQ-025 In UP, after the last beat of j=num_steps: sawtooth SHALL end the chirp; triangle SHALL enter DOWN with j=num_steps-1.
REQ-026 DOWN SHALL decrement j to 0, and the chirp SHALL end after the last beat of j=0; the peak value SHALL NOT be repeated.
REQ-027 If num_steps=0 in triangle mode, DOWN SHALL be skipped, so the chirp is a single step.
REQ-028 tlast SHALL be high on exactly the final accepted beat of each chirp.
REQ-029 At chirp end, when chirps completed < num_chirps or num_chirps=0: the next cycle SHALL present j=0 in UP with no bubble.
REQ-030 Otherwise the block SHALL return to IDLE with tvalid=0 and pulse done for one cycle.
REQ-031 abort=1 in any state SHALL force IDLE on the next edge with tvalid=0, tlast=0 and no done pulse; abort together with gen in IDLE SHALL stay IDLE.
REQ-032 The chirp counter SHALL be CNT_W bits; in continuous mode it SHALL be free-running and its wrap SHALL NOT terminate the run.

Reset
REQ-033 rst=1 SHALL asynchronously force IDLE and clear all counters.
REQ-034 During and after rst: tdata=0, tvalid=0, tlast=0, busy=0, done=0.
REQ-035 rst asserted mid-chirp SHALL discard the sweep; a new gen is required to restart.

Configuration
REQ-036 CHIRP_TRIANGLE_EN defined: the triangle input selects the sweep shape per REQ-025..027.
REQ-037 CHIRP_TRIANGLE_EN undefined: DOWN state and its logic SHALL be absent, triangle is ignored, and the sweep is always sawtooth.

Verification
REQ-038 start=5086, step=1, num_steps=314, dwell=26, chirps=1, tready=1, triangle=0 -> 315x26 beats 5086..5400, tlast on beat 8190, done one cycle later, busy low.
REQ-039 start=100, step=10, num_steps=3, dwell=1, triangle=1, chirps=2 -> tdata 100,110,120,130,120,110,100 twice, tlast on each final 100, one done.
REQ-040 Same as REQ-038 with tready toggling 1/0 every cycle -> identical accepted sequence, tdata stable on stalls, beat count unchanged.
REQ-041 start=0xFFF0, step=0x10, num_steps=2, dwell=0 -> tdata 0xFFF0,0x0000,0x0010 (wrap), one beat each.
REQ-042 chirps=0, abort at beat 500 -> continuous repeats until abort, tvalid low next cycle, no done; rst mid-run -> all outputs 0 immediately.
REQ-043 Build without CHIRP_TRIANGLE_EN, triangle=1, start=100, step=10, num_steps=3, dwell=1 -> sawtooth 100,110,120,130 only.
